// File: rtl/udcounter_driver.sv
// Drives cascaded 74193-style up/down counters (clear/load/inc/dec) and tracks a shadow count.
// Latency: accept -> ASSERT next cycle; busy PULSE_LOW+PULSE_HIGH+1 cycles; all outputs registered.
// Backpressure: cmd_ready high only in IDLE; inputs are ignored while an operation is in flight.
module udcounter_driver #(
  parameter int WIDTH      = 8,
  parameter int PULSE_LOW  = 1,
  parameter int PULSE_HIGH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             cmd_ready,
  output logic             cnt_cpu,
  output logic             cnt_cpd,
  output logic             cnt_pl,
  output logic             cnt_mr,
  output logic [WIDTH-1:0] cnt_d,
  input  logic [WIDTH-1:0] cnt_q,
  output logic [WIDTH-1:0] shadow,
  output logic             carry,
  output logic             borrow,
  output logic             op_done,
  output logic             mismatch
);

  typedef enum logic [1:0] {IDLE, ASSERT, RELEASE, CHECK} state_t;

  localparam logic [1:0]  OP_CLR  = 2'b00;
  localparam logic [1:0]  OP_LOAD = 2'b01;
  localparam logic [1:0]  OP_INC  = 2'b10;
  localparam logic [1:0]  OP_DEC  = 2'b11;
  localparam logic [15:0] LOW_LAST  = 16'(PULSE_LOW - 1);
  localparam logic [15:0] HIGH_LAST = 16'(PULSE_HIGH - 1);

  state_t           state, state_nx;
  logic [15:0]      tmr, tmr_nx;
  logic [1:0]       op_q, op_nx;
  logic [WIDTH-1:0] d_nx, shadow_nx;
  logic             carry_nx, borrow_nx, mismatch_nx;
  logic             cpu_nx, cpd_nx, pl_nx, mr_nx, ready_nx, done_nx;

  // Next-state, shadow arithmetic and registered-pin targets derived from the next state.
  always_comb begin
    state_nx    = state;
    tmr_nx      = tmr;
    op_nx       = op_q;
    d_nx        = cnt_d;
    shadow_nx   = shadow;
    carry_nx    = carry;
    borrow_nx   = borrow;
    mismatch_nx = mismatch;
    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          state_nx  = ASSERT;
          tmr_nx    = '0;
          op_nx     = cmd_op;
          carry_nx  = 1'b0;
          borrow_nx = 1'b0;
          // cnt_d only moves on a load so it never glitches under other ops
          if (cmd_op == OP_LOAD) d_nx = cmd_data;
        end
      end
      ASSERT: begin
        if (tmr == LOW_LAST) begin
          state_nx = RELEASE;
          tmr_nx   = '0;
          // Shadow follows the counter on the releasing (rising) edge
          case (op_q)
            OP_CLR:  shadow_nx = '0;
            OP_LOAD: shadow_nx = cnt_d;
            OP_INC: begin
              shadow_nx = shadow + WIDTH'(1);
              carry_nx  = &shadow;
            end
            default: begin
              shadow_nx = shadow - WIDTH'(1);
              borrow_nx = ~|shadow;
            end
          endcase
        end else begin
          tmr_nx = tmr + 16'd1;
        end
      end
      RELEASE: begin
        if (tmr == HIGH_LAST) begin
          state_nx = CHECK;
          tmr_nx   = '0;
        end else begin
          tmr_nx = tmr + 16'd1;
        end
      end
      default: begin
        state_nx = IDLE;
        if (cnt_q != shadow) mismatch_nx = 1'b1;
      end
    endcase
    // Exactly one pin active during ASSERT, chosen by the latched op
    cpu_nx   = !((state_nx == ASSERT) && (op_nx == OP_INC));
    cpd_nx   = !((state_nx == ASSERT) && (op_nx == OP_DEC));
    pl_nx    = !((state_nx == ASSERT) && (op_nx == OP_LOAD));
    mr_nx    =  ((state_nx == ASSERT) && (op_nx == OP_CLR));
    ready_nx =  (state_nx == IDLE);
    done_nx  =  (state_nx == CHECK);
  end

  // State and output registers; reset holds the counters cleared and aborts any pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      tmr       <= '0;
      op_q      <= OP_CLR;
      cnt_d     <= '0;
      shadow    <= '0;
      carry     <= 1'b0;
      borrow    <= 1'b0;
      mismatch  <= 1'b0;
      cnt_cpu   <= 1'b1;
      cnt_cpd   <= 1'b1;
      cnt_pl    <= 1'b1;
      cnt_mr    <= 1'b1;
      cmd_ready <= 1'b0;
      op_done   <= 1'b0;
    end else begin
      state     <= state_nx;
      tmr       <= tmr_nx;
      op_q      <= op_nx;
      cnt_d     <= d_nx;
      shadow    <= shadow_nx;
      carry     <= carry_nx;
      borrow    <= borrow_nx;
      mismatch  <= mismatch_nx;
      cnt_cpu   <= cpu_nx;
      cnt_cpd   <= cpd_nx;
      cnt_pl    <= pl_nx;
      cnt_mr    <= mr_nx;
      cmd_ready <= ready_nx;
      op_done   <= done_nx;
    end
  end

endmodule

// File: tb/tb_udcounter_driver.sv
// Directed bench for udcounter_driver with a cascaded 193 model behind the default instance.
// A second instance with PULSE_LOW=3 exercises stretched load pulses.
module tb_udcounter_driver;

  localparam logic [1:0] OP_CLR  = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_INC  = 2'b10;
  localparam logic [1:0] OP_DEC  = 2'b11;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic       cmd_ready, cnt_cpu, cnt_cpd, cnt_pl, cnt_mr;
  logic [7:0] cnt_d, cnt_q, shadow;
  logic       carry, borrow, op_done, mismatch;

  logic       v3;
  logic [1:0] op3;
  logic [7:0] d3;
  logic       ready3, cpu3, cpd3, pl3, mr3;
  logic [7:0] cd3, shadow3;
  logic       carry3, borrow3, done3, mm3;
  logic [7:0] q3 = 8'h00;

  int tests = 0;
  int fails = 0;

  udcounter_driver dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .cmd_ready(cmd_ready), .cnt_cpu(cnt_cpu), .cnt_cpd(cnt_cpd), .cnt_pl(cnt_pl), .cnt_mr(cnt_mr),
    .cnt_d(cnt_d), .cnt_q(cnt_q), .shadow(shadow), .carry(carry), .borrow(borrow),
    .op_done(op_done), .mismatch(mismatch)
  );

  udcounter_driver #(.WIDTH(8), .PULSE_LOW(3), .PULSE_HIGH(1)) dut3 (
    .clk(clk), .reset(reset), .cmd_valid(v3), .cmd_op(op3), .cmd_data(d3),
    .cmd_ready(ready3), .cnt_cpu(cpu3), .cnt_cpd(cpd3), .cnt_pl(pl3), .cnt_mr(mr3),
    .cnt_d(cd3), .cnt_q(q3), .shadow(shadow3), .carry(carry3), .borrow(borrow3),
    .op_done(done3), .mismatch(mm3)
  );

  always #5 clk = ~clk;

  // Two cascaded 193s, sampled mid-cycle: mr dominates, then load, then count-clock rising edges.
  logic [7:0] mq = 8'h00;
  logic       pcpu = 1'b1, pcpd = 1'b1;
  logic       stuck = 1'b0;
  int         cpu_run = 0, cpu_w = 0, excl_viol = 0;

  function automatic logic [7:0] ripple(input logic [7:0] q, input logic up);
    logic [7:0] r;
    logic       go;
    r  = q;
    go = 1'b1;
    for (int k = 0; k < 2; k++) begin
      if (go) begin
        if (up) begin
          go = (r[k*4 +: 4] == 4'hF);
          r[k*4 +: 4] = r[k*4 +: 4] + 4'd1;
        end else begin
          go = (r[k*4 +: 4] == 4'h0);
          r[k*4 +: 4] = r[k*4 +: 4] - 4'd1;
        end
      end
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (cnt_mr === 1'b1)                         mq = 8'h00;
    else if (cnt_pl === 1'b0)                    mq = cnt_d;
    else if (cnt_cpu === 1'b1 && pcpu === 1'b0)  mq = ripple(mq, 1'b1);
    else if (cnt_cpd === 1'b1 && pcpd === 1'b0)  mq = ripple(mq, 1'b0);
    pcpu = cnt_cpu;
    pcpd = cnt_cpd;
    if (cnt_cpu === 1'b0) cpu_run++;
    else if (cpu_run > 0) begin
      cpu_w   = cpu_run;
      cpu_run = 0;
    end
    if (cnt_cpu === 1'b0 && cnt_cpd === 1'b0) excl_viol++;
  end

  assign cnt_q = mq & (stuck ? 8'hFB : 8'hFF);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int k = 0;
    while (cmd_ready !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    check("ready_wait", {31'd0, cmd_ready}, 32'd1);
  endtask

  task automatic wait_done();
    int k = 0;
    while (op_done !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    check("done_wait", {31'd0, op_done}, 32'd1);
  endtask

  // Returns during the CHECK cycle of the issued command.
  task automatic send(input logic [1:0] op, input logic [7:0] data);
    wait_ready();
    cmd_op    = op;
    cmd_data  = data;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    wait_done();
  endtask

  initial begin
    int plc, rlc, bad, k, n, cyc, last;
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = OP_CLR; cmd_data = 8'h00;
    v3 = 1'b0; op3 = OP_CLR; d3 = 8'h00;
    tick(); tick();

    // Reset state
    check("rst_mr", {31'd0, cnt_mr}, 32'd1);
    check("rst_ready", {31'd0, cmd_ready}, 32'd0);
    check("rst_pins", {29'd0, cnt_cpu, cnt_cpd, cnt_pl}, 32'd7);
    check("rst_d_shadow", {16'd0, cnt_d, shadow}, 32'd0);
    check("rst_flags", {28'd0, carry, borrow, op_done, mismatch}, 32'd0);
    reset = 1'b0;
    tick();
    check("post_rst_mr", {31'd0, cnt_mr}, 32'd0);
    check("post_rst_ready", {31'd0, cmd_ready}, 32'd1);

    // Stretched load on the PULSE_LOW=3 instance
    op3 = OP_LOAD; d3 = 8'h5A; v3 = 1'b1;
    tick();
    v3 = 1'b0;
    plc = 0; rlc = 0; bad = 0; k = 0;
    while (ready3 !== 1'b1 && k < 20) begin
      if (pl3 === 1'b0) begin
        plc++;
        if (cd3 !== 8'h5A) bad++;
      end
      rlc++;
      tick();
      k++;
    end
    check("pl3_low_cycles", plc, 3);
    check("pl3_data_bad", bad, 0);
    check("ready3_low_cycles", rlc, 5);
    check("shadow3", {24'd0, shadow3}, 32'h5A);

    // Three increments
    for (int i = 1; i <= 3; i++) begin
      send(OP_INC, 8'h00);
      check("inc_shadow", {24'd0, shadow}, i);
      check("inc_cnt_q", {24'd0, cnt_q}, i);
      check("cpu_width", cpu_w, 1);
    end
    tick();
    check("inc_mismatch", {31'd0, mismatch}, 32'd0);

    // Wrap up and down through the nibble cascade
    send(OP_LOAD, 8'hFF);
    check("load_ff_shadow", {24'd0, shadow}, 32'hFF);
    check("load_ff_q", {24'd0, cnt_q}, 32'hFF);
    send(OP_INC, 8'h00);
    check("wrap_shadow", {24'd0, shadow}, 32'h00);
    check("wrap_carry", {31'd0, carry}, 32'd1);
    check("wrap_q", {24'd0, cnt_q}, 32'h00);
    send(OP_DEC, 8'h00);
    check("unwrap_shadow", {24'd0, shadow}, 32'hFF);
    check("unwrap_cb", {30'd0, carry, borrow}, 32'd1);
    check("unwrap_q", {24'd0, cnt_q}, 32'hFF);

    // Back-to-back increments with valid held
    send(OP_CLR, 8'h00);
    check("clr_shadow", {24'd0, shadow}, 32'h00);
    cmd_op = OP_INC; cmd_valid = 1'b1;
    n = 0; cyc = 0; last = 0;
    while (n < 10 && cyc < 100) begin
      if (cmd_ready === 1'b1) begin
        if (n > 0) check("b2b_gap", cyc - last, 4);
        last = cyc;
        n++;
      end
      tick();
      cyc++;
    end
    cmd_valid = 1'b0;
    check("b2b_count", n, 10);
    wait_done();
    check("b2b_shadow", {24'd0, shadow}, 32'd10);
    check("b2b_q", {24'd0, cnt_q}, 32'd10);

    // Reset during ASSERT of a decrement from 0x10
    send(OP_LOAD, 8'h10);
    check("load10_shadow", {24'd0, shadow}, 32'h10);
    wait_ready();
    cmd_op = OP_DEC; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    check("abort_cpd_low", {31'd0, cnt_cpd}, 32'd0);
    reset = 1'b1;
    tick();
    check("abort_cpd_mr", {30'd0, cnt_cpd, cnt_mr}, 32'd3);
    check("abort_shadow", {24'd0, shadow}, 32'h00);
    reset = 1'b0;
    tick();
    check("abort_q", {24'd0, cnt_q}, 32'h00);
    check("abort_mr_rel", {31'd0, cnt_mr}, 32'd0);

    // Stuck-at-0 on cnt_q[2]
    stuck = 1'b1;
    for (int i = 1; i <= 3; i++) send(OP_INC, 8'h00);
    tick();
    check("stuck_mm_3", {31'd0, mismatch}, 32'd0);
    send(OP_INC, 8'h00);
    check("stuck_shadow4", {24'd0, shadow}, 32'h04);
    tick();
    check("stuck_mm_4", {31'd0, mismatch}, 32'd1);
    send(OP_LOAD, 8'h01);
    tick();
    check("stuck_mm_sticky", {31'd0, mismatch}, 32'd1);
    reset = 1'b1;
    tick();
    check("stuck_mm_reset", {31'd0, mismatch}, 32'd0);
    reset = 1'b0;
    tick();

    check("cpu_cpd_exclusive", excl_viol, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
